// File: rtl/ledpanel_pkg.sv
// Shared definitions for the LED panel write path: swap FSM states and
// width derivations used by both this controller and the panel datapath.
package ledpanel_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_WAIT_VS = 2'd2
    } swap_state_e;

    // Pixel address width: {half, row, col}, the MSB selects the lower half.
    function automatic int calc_aw(input int rows_lines, input int cols_lines);
        return rows_lines + cols_lines + 1;
    endfunction

    // Pixel word width: three colour channels.
    function automatic int calc_dw(input int color_bits);
        return 3 * color_bits;
    endfunction

endpackage

// File: rtl/ledpanel_fill_engine.sv
// Fill engine: walks every word of the back buffer once, writing a single
// latched colour. It advances only when the arbiter grants it a write.
module ledpanel_fill_engine
    import ledpanel_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 24
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [DW-1:0] color_i,
    input  logic          grant_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);

    localparam logic [AW-1:0] LAST_ADDR = '1;

    logic          busy_q;
    logic          done_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic [DW-1:0] color_q;

    // Next word address; at LAST_ADDR the fill ends instead of wrapping.
    always_comb begin
        cnt_d = cnt_q + AW'(1);
    end

    // Start latches the colour; each grant consumes one word; the last grant ends the fill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            color_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                color_q <= color_i;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else if (busy_q && grant_i) begin
                if (cnt_q == LAST_ADDR) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign addr_o = cnt_q;
    assign data_o = color_q;

endmodule

// File: rtl/ledpanel_fb_ctrl.sv
// Write-side framebuffer controller: shares the panel's single write port
// between the host and the fill engine (round-robin on contention) and
// swaps front/back buffers only on v_sync once the fill has drained.
// Handshake: the host holds host_write with address/data stable; the word
// is taken in a cycle where host_write && !host_waitrequest, and appears on
// memAddrIn/memDataIn/memWrite one clock later.
module ledpanel_fb_ctrl
    import ledpanel_pkg::*;
#(
    parameter int COLOR_BITS         = 8,
    parameter int DISPLAY_ROWS_LINES = 4,
    parameter int DISPLAY_COLS_LINES = 6,
    localparam int AW = calc_aw(DISPLAY_ROWS_LINES, DISPLAY_COLS_LINES),
    localparam int DW = calc_dw(COLOR_BITS)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    input  logic          host_write,
    output logic          host_waitrequest,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    output logic          fill_done,
    input  logic          swap_req,
    output logic          swap_pending,
    output logic          swap_done,
    input  logic          v_sync,
    output logic [AW-1:0] memAddrIn,
    output logic [DW-1:0] memDataIn,
    output logic          memWrite,
    output logic          backbuffer
);

    swap_state_e   state_q;
    logic          swap_pending_q;
    logic          swap_done_q;
    logic          backbuffer_q;

    logic          rr_fill_q;     // 1: fill wins the next contention
    logic          rr_fill_d;
    logic          mem_we_q;
    logic          mem_we_d;
    logic [AW-1:0] mem_addr_q;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_data_q;
    logic [DW-1:0] mem_data_d;

    logic          host_wait;
    logic          host_req;
    logic          grant_host;
    logic          grant_fill;
    logic          contention;
    logic          fill_busy_w;
    logic          fill_done_w;
    logic [AW-1:0] fill_addr_w;
    logic [DW-1:0] fill_data_w;

    // A new fill may not begin while a swap is waiting for the buffer to settle.
    ledpanel_fill_engine #(
        .AW (AW),
        .DW (DW)
    ) u_fill (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .start_i (fill_start & ~swap_pending_q),
        .color_i (fill_color),
        .grant_i (grant_fill),
        .busy_o  (fill_busy_w),
        .done_o  (fill_done_w),
        .addr_o  (fill_addr_w),
        .data_o  (fill_data_w)
    );

    // Arbitration: host is stalled during a swap; on contention the last loser wins.
    always_comb begin
        host_req   = host_write & ~swap_pending_q;
        host_wait  = swap_pending_q | (fill_busy_w & host_write & rr_fill_q);
        grant_host = host_write & ~host_wait;
        grant_fill = fill_busy_w & ~grant_host;
        contention = host_req & fill_busy_w;
        rr_fill_d  = contention ? grant_host : rr_fill_q;
        mem_we_d   = grant_host | grant_fill;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (grant_host) begin
            mem_addr_d = host_addr;
            mem_data_d = host_data;
        end else if (grant_fill) begin
            mem_addr_d = fill_addr_w;
            mem_data_d = fill_data_w;
        end
    end

    // Registered write port and round-robin pointer (host favoured out of reset).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rr_fill_q  <= 1'b0;
        end else begin
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rr_fill_q  <= rr_fill_d;
        end
    end

    // Swap FSM: request, drain the fill, then flip the buffer on the next v_sync.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= S_IDLE;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            backbuffer_q   <= 1'b0;
        end else begin
            swap_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (swap_req) begin
                        state_q        <= S_DRAIN;
                        swap_pending_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!fill_busy_w) begin
                        state_q <= S_WAIT_VS;
                    end
                end
                S_WAIT_VS: begin
                    if (v_sync) begin
                        state_q        <= S_IDLE;
                        swap_pending_q <= 1'b0;
                        swap_done_q    <= 1'b1;
                        backbuffer_q   <= ~backbuffer_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign host_waitrequest = host_wait;
    assign fill_busy        = fill_busy_w;
    assign fill_done        = fill_done_w;
    assign swap_pending     = swap_pending_q;
    assign swap_done        = swap_done_q;
    assign backbuffer       = backbuffer_q;
    assign memWrite         = mem_we_q;
    assign memAddrIn        = mem_addr_q;
    assign memDataIn        = mem_data_q;

endmodule

// File: tb/tb_ledpanel_fb_ctrl.sv
// Self-checking bench for ledpanel_fb_ctrl: directed scenarios plus a random
// phase, all checked cycle by cycle against a behavioural model of the
// sharing / fill / swap rules.
module tb_ledpanel_fb_ctrl;

    localparam int AW     = 11;
    localparam int DW     = 24;
    localparam int NWORDS = 2048;

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_data = '0;
    logic          host_write = 1'b0;
    logic          host_waitrequest;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_color = '0;
    logic          fill_busy;
    logic          fill_done;
    logic          swap_req = 1'b0;
    logic          swap_pending;
    logic          swap_done;
    logic          v_sync = 1'b0;
    logic [AW-1:0] memAddrIn;
    logic [DW-1:0] memDataIn;
    logic          memWrite;
    logic          backbuffer;

    always #5 CLK = ~CLK;

    ledpanel_fb_ctrl dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .host_addr        (host_addr),
        .host_data        (host_data),
        .host_write       (host_write),
        .host_waitrequest (host_waitrequest),
        .fill_start       (fill_start),
        .fill_color       (fill_color),
        .fill_busy        (fill_busy),
        .fill_done        (fill_done),
        .swap_req         (swap_req),
        .swap_pending     (swap_pending),
        .swap_done        (swap_done),
        .v_sync           (v_sync),
        .memAddrIn        (memAddrIn),
        .memDataIn        (memDataIn),
        .memWrite         (memWrite),
        .backbuffer       (backbuffer)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_fill_on;     // a fill is sweeping the buffer
    int            m_fill_idx;    // next word the fill will write
    logic [DW-1:0] m_fill_col;
    logic          m_host_turn;   // host wins the next tie
    logic          m_swap_req;    // swap requested, not yet taken
    logic          m_drained;     // fill finished since the request
    logic          m_bb;

    task automatic model_reset();
        m_fill_on   = 1'b0;
        m_fill_idx  = 0;
        m_fill_col  = '0;
        m_host_turn = 1'b1;
        m_swap_req  = 1'b0;
        m_drained   = 1'b0;
        m_bb        = 1'b0;
        exp_q.delete();
    endtask

    // observation counters and host driver state
    int obs_writes = 0;
    int obs_fdone = 0;
    int obs_sdone = 0;
    int host_accepts = 0;
    int host_age = 0;
    int lat_max = 0;
    int host_rate = 0;

    task automatic new_host_req();
        host_addr  = AW'($urandom_range(0, NWORDS - 1));
        host_data  = DW'($urandom);
        host_write = 1'b1;
        host_age   = 0;
    endtask

    // One clock cycle: called at a negedge with inputs already driven.
    task automatic step();
        logic host_ok, host_wins, fill_wins, exp_wait, exp_fdone, exp_sdone;
        logic accepted, fill_was_on, exp_we;
        logic [AW+DW-1:0] wr;
        #1;
        host_ok   = host_write && !m_swap_req;
        host_wins = host_ok && (!m_fill_on || m_host_turn);
        fill_wins = m_fill_on && !host_wins;
        exp_wait  = m_swap_req || (m_fill_on && host_write && !m_host_turn);
        check_eq("host_waitrequest", host_waitrequest, exp_wait);
        accepted  = host_write && !host_waitrequest;
        exp_we    = host_wins || fill_wins;
        exp_q.delete();
        if (host_wins) exp_q.push_back({host_addr, host_data});
        else if (fill_wins) exp_q.push_back({AW'(m_fill_idx), m_fill_col});
        exp_fdone = fill_wins && (m_fill_idx == NWORDS - 1);
        if (host_ok && m_fill_on) m_host_turn = !host_wins;
        fill_was_on = m_fill_on;
        if (fill_wins) begin
            if (exp_fdone) m_fill_on = 1'b0;
            else m_fill_idx++;
        end
        if (fill_start && !fill_was_on && !m_swap_req) begin
            m_fill_on  = 1'b1;
            m_fill_idx = 0;
            m_fill_col = fill_color;
        end
        exp_sdone = 1'b0;
        if (!m_swap_req) begin
            if (swap_req) begin
                m_swap_req = 1'b1;
                m_drained  = 1'b0;
            end
        end else if (!m_drained) begin
            if (!fill_was_on) m_drained = 1'b1;
        end else if (v_sync) begin
            m_bb       = !m_bb;
            m_swap_req = 1'b0;
            exp_sdone  = 1'b1;
        end

        @(posedge CLK);
        #1;
        if (memWrite) obs_writes++;
        if (fill_done) obs_fdone++;
        if (swap_done) obs_sdone++;
        check_eq("memWrite", memWrite, exp_we);
        if (memWrite && exp_q.size() > 0) begin
            wr = exp_q.pop_front();
            check_eq("memAddrIn", memAddrIn, wr[AW+DW-1:DW]);
            check_eq("memDataIn", memDataIn, wr[DW-1:0]);
        end
        check_eq("fill_busy", fill_busy, m_fill_on);
        check_eq("fill_done", fill_done, exp_fdone);
        check_eq("swap_pending", swap_pending, m_swap_req);
        check_eq("swap_done", swap_done, exp_sdone);
        check_eq("backbuffer", backbuffer, m_bb);

        @(negedge CLK);
        fill_start = 1'b0;
        swap_req   = 1'b0;
        v_sync     = 1'b0;
        if (accepted) begin
            host_accepts++;
            if (host_age + 1 > lat_max) lat_max = host_age + 1;
            if ($urandom_range(0, 99) < host_rate) new_host_req();
            else host_write = 1'b0;
        end else if (host_write) begin
            host_age++;
        end else if ($urandom_range(0, 99) < host_rate) begin
            new_host_req();
        end
    endtask

    task automatic clear_counts();
        obs_writes   = 0;
        obs_fdone    = 0;
        obs_sdone    = 0;
        host_accepts = 0;
        lat_max      = 0;
    endtask

    task automatic run_until_fill_idle(input string tag, input int budget);
        int n = 0;
        while (m_fill_on && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, fill_busy, 1'b0);
    endtask

    task automatic run_until_fill_idx(input int idx);
        int n = 0;
        while (m_fill_idx < idx && m_fill_on && n < 3 * NWORDS) begin
            step();
            n++;
        end
    endtask

    task automatic start_fill(input logic [DW-1:0] col);
        fill_color = col;
        fill_start = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic bb_before;
        int   n;
        model_reset();
        repeat (3) @(negedge CLK);
        #1;
        check_eq("rst_memWrite", memWrite, 1'b0);
        check_eq("rst_memAddrIn", memAddrIn, '0);
        check_eq("rst_memDataIn", memDataIn, '0);
        check_eq("rst_backbuffer", backbuffer, 1'b0);
        check_eq("rst_fill_busy", fill_busy, 1'b0);
        check_eq("rst_swap_pending", swap_pending, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        step();

        // 1: lone host write
        host_addr  = 11'h005;
        host_data  = 24'h112233;
        host_write = 1'b1;
        step();
        step();

        // 2: uncontended fill
        clear_counts();
        start_fill(24'h00FF00);
        run_until_fill_idle("fill_timeout", NWORDS + 10);
        repeat (3) step();
        check_eq("fill_writes", obs_writes, NWORDS);
        check_eq("fill_done_pulses", obs_fdone, 1);

        // 3: fill with continuous host traffic
        clear_counts();
        host_rate = 100;
        new_host_req();
        start_fill(DW'($urandom));
        run_until_fill_idle("contended_fill_timeout", 3 * NWORDS);
        host_rate = 0;
        n = 0;
        while (host_write && n < 10) begin step(); n++; end
        check_eq("host_latency_le2", (lat_max <= 2), 1'b1);
        check_eq("fill_grants", obs_writes - host_accepts, NWORDS);

        // 4: swap requested mid-fill, host stalled meanwhile
        clear_counts();
        start_fill(24'hA5A5A5);
        run_until_fill_idx(12'h100);
        swap_req = 1'b1;
        new_host_req();
        step();
        run_until_fill_idle("swap_drain_timeout", 2 * NWORDS);
        repeat (10) step();
        check_eq("bb_before_vsync", backbuffer, 1'b0);
        v_sync = 1'b1;
        step();
        repeat (3) step();
        check_eq("bb_after_swap", backbuffer, 1'b1);
        check_eq("swap_done_pulses", obs_sdone, 1);

        // 5: v_sync during drain is missed
        clear_counts();
        start_fill(DW'($urandom));
        run_until_fill_idx(2000);
        swap_req = 1'b1;
        step();
        repeat (5) step();
        v_sync = 1'b1;
        step();
        bb_before = backbuffer;
        for (int i = 1; i < 100; i++) step();
        check_eq("bb_missed_vsync", backbuffer, bb_before);
        check_eq("fill_drained_first", fill_busy, 1'b0);
        v_sync = 1'b1;
        step();
        check_eq("bb_second_vsync", backbuffer, !bb_before);
        check_eq("swap_done_once", obs_sdone, 1);

        // random phase
        host_rate = 30;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                fill_color = DW'($urandom);
                fill_start = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) swap_req = 1'b1;
            if ($urandom_range(0, 39) == 0) v_sync = 1'b1;
            step();
        end
        host_rate = 0;
        n = 0;
        while ((m_fill_on || m_swap_req || host_write) && n < 3 * NWORDS) begin
            if (n % 20 == 19) v_sync = 1'b1;
            step();
            n++;
        end
        check_eq("settle_idle", fill_busy | swap_pending | host_write, 1'b0);

        // 6: reset mid-fill
        start_fill(24'h123456);
        run_until_fill_idx(12'h300);
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("midrst_memWrite", memWrite, 1'b0);
        check_eq("midrst_fill_busy", fill_busy, 1'b0);
        check_eq("midrst_backbuffer", backbuffer, 1'b0);
        check_eq("midrst_swap_pending", swap_pending, 1'b0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        clear_counts();
        repeat (30) step();
        check_eq("postrst_no_writes", obs_writes, 0);
        new_host_req();
        step();
        step();
        check_eq("postrst_host_write", obs_writes, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
